// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Arbiter and sequencer for the single-port data DRAM. Requester m0 (CPU)
//   issues single-word accesses; requester m1 (DMA/debug loader) issues
//   incrementing bursts. Ties are broken round-robin, and a long m1 burst is
//   paused after MAX_WAIT consecutive beats with m0 waiting, so the CPU sees
//   a bounded latency.
//
//   Ports
//     fpga_clk, fpga_rst          clock, synchronous active-high reset
//     m0_req/we/addr/wdata        CPU request (byte address), held until ack
//     m0_ack, m0_rdata            access done this cycle, read data
//     m1_req/we/addr/len/wdata    burst request, held until done
//     m1_ack, m1_rdata, m1_done   one beat this cycle, beat data, last beat
//     dram_a/we/d, dram_spo       DRAM word address, write strobe, data in/out
//
//   state  | meaning
//   IDLE   | arbitrate between pending requests
//   SERVE0 | one CPU access; returns to SERVE1 if a burst was preempted
//   SERVE1 | one burst beat per cycle
module dmem_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int MAX_BURST = 16,
  parameter int MAX_WAIT  = 4
) (
  input  logic              fpga_clk,
  input  logic              fpga_rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [31:0]       m0_addr,
  input  logic [31:0]       m0_wdata,
  output logic              m0_ack,
  output logic [31:0]       m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [31:0]       m1_addr,
  input  logic [4:0]        m1_len,
  input  logic [31:0]       m1_wdata,
  output logic              m1_ack,
  output logic [31:0]       m1_rdata,
  output logic              m1_done,
  output logic [ADDR_W-1:0] dram_a,
  output logic              dram_we,
  output logic [31:0]       dram_d,
  input  logic [31:0]       dram_spo
);

  localparam int LEN_W  = $clog2(MAX_BURST + 1);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SERVE0 = 2'd1;
  localparam logic [1:0] S_SERVE1 = 2'd2;

  logic [1:0]        state;
  logic              rr_ptr;
  logic              resume;
  logic [LEN_W-1:0]  beat_cnt;
  logic [LEN_W-1:0]  len_eff;
  logic [WAIT_W-1:0] wait_cnt;
  logic [ADDR_W-1:0] a_hold;
  logic [31:0]       d_hold;

  logic              serve0;
  logic              serve1;
  logic              last_beat;
  logic              grant0;
  logic              grant1;
  logic [31:0]       beat_addr;
  logic [LEN_W-1:0]  len_req;
  logic [WAIT_W-1:0] wait_next;
  logic              unused_bits;

  // Acks and the write strobe are masked during reset so an aborted burst
  // never commits a beat or signals done in the reset cycle.
  assign serve0 = (state == S_SERVE0) && !fpga_rst;
  assign serve1 = (state == S_SERVE1) && !fpga_rst;

  // Address follows the live m1_addr; only the beat count is internal.
  assign beat_addr = m1_addr + (32'(beat_cnt) << 2);
  assign last_beat = (beat_cnt == len_eff - LEN_W'(1));

  assign grant0 = m0_req && (!m1_req || !rr_ptr);
  assign grant1 = m1_req && (!m0_req || rr_ptr);

  assign wait_next = m0_req ? wait_cnt + WAIT_W'(1) : '0;

  always_comb begin
    len_req = LEN_W'(m1_len);
    if (m1_len == 5'd0) begin
      len_req = LEN_W'(1);
    end else if (32'(m1_len) > 32'(MAX_BURST)) begin
      len_req = LEN_W'(MAX_BURST);
    end
  end

  always_comb begin
    dram_a = a_hold;
    dram_d = d_hold;
    case (state)
      S_SERVE0: begin
        dram_a = m0_addr[ADDR_W+1:2];
        dram_d = m0_wdata;
      end
      S_SERVE1: begin
        dram_a = beat_addr[ADDR_W+1:2];
        dram_d = m1_wdata;
      end
      default: ;
    endcase
  end

  assign dram_we  = (serve0 && m0_we) || (serve1 && m1_we);
  assign m0_ack   = serve0;
  assign m1_ack   = serve1;
  assign m1_done  = serve1 && last_beat;
  assign m0_rdata = dram_spo;
  assign m1_rdata = dram_spo;

  assign unused_bits = ^{m0_addr[31:ADDR_W+2], m0_addr[1:0],
                         beat_addr[31:ADDR_W+2], beat_addr[1:0]};

  always_ff @(posedge fpga_clk) begin
    if (fpga_rst) begin
      state    <= S_IDLE;
      rr_ptr   <= 1'b0;
      resume   <= 1'b0;
      beat_cnt <= '0;
      len_eff  <= '0;
      wait_cnt <= '0;
      a_hold   <= '0;
      d_hold   <= '0;
    end else begin
      a_hold <= dram_a;
      d_hold <= dram_d;
      case (state)
        S_IDLE: begin
          if (grant0) begin
            state  <= S_SERVE0;
            rr_ptr <= 1'b1;
          end else if (grant1) begin
            state    <= S_SERVE1;
            rr_ptr   <= 1'b0;
            len_eff  <= len_req;
            beat_cnt <= '0;
            wait_cnt <= '0;
            resume   <= 1'b0;
          end
        end
        S_SERVE0: begin
          state <= resume ? S_SERVE1 : S_IDLE;
        end
        S_SERVE1: begin
          beat_cnt <= beat_cnt + LEN_W'(1);
          if (last_beat) begin
            state    <= S_IDLE;
            resume   <= 1'b0;
            wait_cnt <= '0;
          end else if (wait_next == WAIT_W'(MAX_WAIT)) begin
            // Pause the burst for one CPU access; beat_cnt/len_eff are kept.
            state    <= S_SERVE0;
            resume   <= 1'b1;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_next;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-requester arbiter and sequencer for the single-port data DRAM (16-bit word address, combinational read, write on clock edge).
- Requester 0 is the CPU data port: single-word accesses.
- Requester 1 is a DMA/debug loader: incrementing bursts.
- Sits between the requesters and DRAM in the SoC top. Fair round-robin arbitration; bounded CPU wait during long bursts.

Parameters:
ADDR_W, 16, DRAM word-address width.
MAX_BURST, 16, maximum beats per m1 burst.
MAX_WAIT, 4, maximum m1 beats served while m0_req waits before m1 is preempted.

Ports:
fpga_clk  in  1  clock.
fpga_rst  in  1  synchronous reset, active high.
m0_req  in  1  CPU access request; held until m0_ack.
m0_we  in  1  CPU write enable.
m0_addr  in  32  CPU byte address.
m0_wdata  in  32  CPU write data.
m0_ack  out  1  access performed this cycle.
m0_rdata  out  32  read data, valid while m0_ack=1.
m1_req  in  1  burst request; held until m1_done.
m1_we  in  1  burst direction (1 = write).
m1_addr  in  32  burst start byte address.
m1_len  in  5  beat count.
m1_wdata  in  32  current beat write data; advanced by m1 after each m1_ack.
m1_ack  out  1  one beat performed this cycle.
m1_rdata  out  32  beat read data, valid while m1_ack=1.
m1_done  out  1  final beat of the burst, coincident with its m1_ack.
dram_a  out  ADDR_W  word address = selected byte address[ADDR_W+1:2].
dram_we  out  1  DRAM write enable.
dram_d  out  32  DRAM write data.
dram_spo  in  32  DRAM read data (combinational).

Behaviour:
- The clock is fpga_clk. fpga_rst is synchronous and active-high.
- Reset values:
  - state = IDLE, rr_ptr = 0 (m0 wins the first tie), beat_cnt = 0, wait_cnt = 0.
  - All ack/done outputs 0, dram_we = 0, dram_a = 0, dram_d = 0.
- States: IDLE, SERVE0, SERVE1.
- IDLE:
  - No request: stay in IDLE.
  - Only one req: grant it.
  - Both req: grant the requester indicated by rr_ptr.
  - On any grant, rr_ptr is set to the other requester.
  - On a fresh m1 grant, latch len_eff = (m1_len==0) ? 1 : min(m1_len, MAX_BURST) and clear beat_cnt.
- SERVE0:
  - Lasts exactly 1 cycle. DRAM is driven from m0 fields; dram_we = m0_we.
  - m0_ack = 1; m0_rdata = dram_spo.
  - A write commits at the closing edge.
  - Next state: IDLE, or SERVE1 directly if resuming a preempted burst (resume flag set).
  - A CPU access therefore costs 2 cycles minimum: SERVE0 plus the IDLE re-arbitration, during which the requester drops req.
- SERVE1:
  - Each cycle is one beat. dram_a is derived from m1_addr + 4*beat_cnt (wraps modulo 2^32).
  - dram_we = m1_we; dram_d = m1_wdata; m1_ack = 1; m1_rdata = dram_spo; beat_cnt increments.
  - Last beat (beat_cnt == len_eff-1): m1_done = 1, clear resume, go to IDLE.
  - wait_cnt counts consecutive SERVE1 beats with m0_req = 1, and clears when m0_req = 0.
  - When wait_cnt reaches MAX_WAIT and the beat is not the last: set resume, go to SERVE0.
  - The resumed burst keeps beat_cnt and len_eff, so it does not restart. wait_cnt clears on preemption.
- Outside SERVE states: dram_we = 0, all acks = 0. dram_a/dram_d hold the last value (don't-care).
- A request deasserted before its grant is dropped without an ack.
- m1 changing m1_addr, m1_len or m1_we mid-burst is illegal. The latched len_eff is used; the address follows the live m1_addr.
- Reset mid-burst aborts immediately. m1_done is never issued for the aborted burst, and no DRAM write occurs in the reset cycle.
- Worst-case m0 latency from req to ack while a burst is running: MAX_WAIT+1 cycles.

Test Plan:
- Reset, then m0 write 0xDEADBEEF to 0x00000010, then a read of 0x10:
  - Write: m0_ack one cycle after req, dram_a = 0x0004, dram_we = 1.
  - Read: m0_rdata = 0xDEADBEEF.
- m0_req and m1_req rise together from reset:
  - m0 is served first (rr_ptr = 0).
  - Next simultaneous tie: m1 first.
- m1 write burst, len = 4, base 0x100, data 1..4: four consecutive m1_ack cycles with dram_a = 0x40..0x43; m1_done on the 4th. Readback by m0 returns 1..4.
- m1 burst, len = 16, with m0_req raised at beat 2:
  - m1 serves 4 more beats, then SERVE0 (m0_ack).
  - The burst resumes at beat 6 and finishes with 16 total m1_acks, m1_done once.
- m1_len = 0 gives 1 beat plus done. m1_len = 31 is clamped to 16 beats.
- fpga_rst asserted at beat 3 of a len-8 write burst:
  - Next cycle: all outputs at reset values, no m1_done.
  - DRAM locations for beats 3..7 are unchanged.
